alu_seq_exec: RTL and testbench
===============================

Name: alu_seq_exec

Overview:
- Execution-side partner of the ALU control decoder. Consumes the 4-bit ALU control code and two operands, and returns a registered result with status flags.
- Uses a valid/ready handshake on both input and output.
- Single-cycle logic ops complete in one cycle. Multiply runs as an iterative shift-add over WIDTH cycles.
- Sits in the EX stage of the multi-cycle datapath and stalls the controller through in_ready_o.

Parameters:
- WIDTH, 32, operand and result width in bits (must be at least 2).

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  reset, asynchronous, active-low.
- in_valid_i  input  1  operation request.
- in_ready_o  output  1  block can accept an operation.
- ALUCtrl_i  input  4  operation code.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- out_valid_o  output  1  result available.
- out_ready_i  input  1  consumer takes the result.
- result_o  output  WIDTH  registered result.
- zero_o  output  1  result_o == 0.
- overflow_o  output  1  signed overflow (add and sub only).
- err_o  output  1  illegal operation code.
- busy_o  output  1  multiply in progress.

Behaviour:
- Codes:
  - 0010 add
  - 0110 sub
  - 0000 and
  - 0001 or
  - 0111 slt (signed)
  - 0011 mul (only with the optional feature)
  - any other code is illegal, including 1111.
- States: IDLE, MUL, DONE.
- Reset (rst_i low, asynchronous): state IDLE; result_o, zero_o, overflow_o, err_o, out_valid_o, busy_o and the iteration counter all 0. A reset during MUL or DONE abandons the operation with no output.
- in_ready_o = 1 only in IDLE. It is combinational from state, never from inputs.
- Accept when in_valid_i & in_ready_o at an edge. ALUCtrl_i, src1_i and src2_i are sampled only at that edge and ignored at all other times.
- Non-mul op accepted at edge k: result and flags are registered at edge k and the state goes to DONE. out_valid_o is high in the following cycle (1-cycle latency).
- Mul accepted at edge k:
  - State goes to MUL; busy_o = 1; counter = 0.
  - Operands are latched: multiplicand A, multiplier B, accumulator 0.
  - Each edge in MUL: if B[0] then accumulator += A; then A <<= 1, B >>= 1, counter++.
  - After WIDTH iterations (edge k+WIDTH): state goes to DONE; busy_o = 0; result_o = accumulator. This is the low WIDTH bits of the product, identical for signed and unsigned operands.
- DONE:
  - out_valid_o = 1; outputs are held stable.
  - On the edge where out_ready_i = 1, go to IDLE and drop out_valid_o.
  - result_o and the flags keep their values until the next completion.
- Throughput: at most one operation every 2 cycles for non-mul ops. No accept is possible while in DONE, even if out_ready_i is high in the same cycle.
- add/sub: WIDTH-bit wrap-around. overflow_o = the operand signs that permit overflow match, and the result sign differs from them. Concretely, for add the operand signs are equal; for sub the sign of A differs from the sign of B.
- slt:
  - result_o = 1 if src1 < src2 as signed two's complement, else 0.
  - Must be correct when src1 - src2 overflows (use the sign bit XOR the overflow bit).
  - overflow_o = 0.
- and/or/mul: overflow_o = 0.
- Illegal code: completes in 1 cycle with result_o = 0, zero_o = 0, overflow_o = 0, err_o = 1. err_o = 0 for every legal op.
- zero_o = (result_o == 0), except for illegal codes as stated above.
- in_valid_i held high while in_ready_o = 0 has no effect.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: code 0011 is the iterative multiply described above. State MUL, busy_o and the counter exist.
- Undefined: code 0011 is illegal (err_o = 1, 1-cycle latency). State MUL and the multiplier datapath are not synthesized. busy_o is tied to 0.

Test Plan:
- Reset and add:
  - Stimulus: hold rst_i low 3 cycles and check all outputs are 0 and in_ready_o = 1. Release, then issue add 0x7FFFFFFF + 0x00000001.
  - Response: next cycle out_valid_o = 1, result 0x80000000, overflow_o = 1, zero_o = 0.
- Sub to zero:
  - Stimulus: sub 5 - 5, with out_ready_i held low for 4 cycles.
  - Response: result 0 and zero_o = 1, held stable for 4 cycles. in_ready_o = 0 throughout. After out_ready_i is raised, IDLE follows.
- slt across the overflow boundary:
  - Stimulus: slt 0x80000000 vs 0x00000001.
  - Response: result 1.
  - Stimulus: slt 0x7FFFFFFF vs 0xFFFFFFFF.
  - Response: result 0. overflow_o = 0 in both cases.
- Illegal code:
  - Stimulus: ALUCtrl_i = 1111 with operands 3, 4.
  - Response: err_o = 1, result 0, zero_o = 0.
  - Stimulus: a following and 0xF0 & 0x3C.
  - Response: 0x30 with err_o = 0.
- Multiply (macro defined):
  - Stimulus: mul 0xFFFFFFFF * 3.
  - Response: busy_o high 32 cycles, out_valid_o exactly 32 cycles after the single-op timing point, result 0xFFFFFFFD.
  - Macro undefined: same stimulus gives err_o = 1 after 1 cycle.
- Reset mid-multiply:
  - Stimulus: assert rst_i at iteration 10 of mul 7 * 9.
  - Response: immediate IDLE, out_valid_o never rises, all outputs 0. A subsequent add 2 + 2 gives 4.

Source files
------------

// File: rtl/alu_seq_exec_if.sv
// alu_seq_exec_if: request/response handshake bundle for the EX-stage ALU.
// slave is the ALU side; master is the controller side.
interface alu_seq_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [3:0]       ALUCtrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             overflow_o;
  logic             err_o;
  logic             busy_o;

  modport slave (
    input  in_valid_i, ALUCtrl_i, src1_i, src2_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o, result_o,
    output zero_o, overflow_o, err_o, busy_o
  );

  modport master (
    output in_valid_i, ALUCtrl_i, src1_i, src2_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o, result_o,
    input  zero_o, overflow_o, err_o, busy_o
  );
endinterface

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: EX-stage ALU with valid/ready handshake and registered flags.
// Define ALU_SEQ_MUL_EN to add the iterative shift-add multiply on code 0011.
module alu_seq_exec #(
  parameter int WIDTH = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_seq_exec_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_SLT = 4'b0111;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b0011;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`endif

  state_t state, state_n;

  logic [WIDTH-1:0] a, b, sum, diff;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c, err_c;
  logic             add_ovf, sub_ovf, slt_bit;
  logic             accept, start_mul;
  logic             op_add, op_sub, op_and, op_or, op_slt;

  logic [WIDTH-1:0] result_q;
  logic             zero_q, ovf_q, err_q;

  assign a      = bus.src1_i;
  assign b      = bus.src2_i;
  assign accept = bus.in_valid_i && (state == IDLE);

  assign op_add = bus.ALUCtrl_i == OP_ADD;
  assign op_sub = bus.ALUCtrl_i == OP_SUB;
  assign op_and = bus.ALUCtrl_i == OP_AND;
  assign op_or  = bus.ALUCtrl_i == OP_OR;
  assign op_slt = bus.ALUCtrl_i == OP_SLT;

`ifdef ALU_SEQ_MUL_EN
  assign start_mul = bus.ALUCtrl_i == OP_MUL;
`else
  assign start_mul = 1'b0;
`endif

  assign sum  = a + b;
  assign diff = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1])
                && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1])
                && (diff[WIDTH-1] != a[WIDTH-1]);
  // sign of a-b corrected by overflow gives a true signed compare
  assign slt_bit = diff[WIDTH-1] ^ sub_ovf;

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    err_c = 1'b0;
    unique case (1'b1)
      op_add: begin
        res_c = sum;
        ovf_c = add_ovf;
      end
      op_sub: begin
        res_c = diff;
        ovf_c = sub_ovf;
      end
      op_and: res_c = a & b;
      op_or:  res_c = a | b;
      op_slt: res_c = {{(WIDTH-1){1'b0}}, slt_bit};
      default: err_c = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] ma, mb, acc, acc_n;
  logic [CW-1:0]    cnt;
  logic             last;

  assign acc_n = acc + (mb[0] ? ma : '0);
  assign last  = cnt == CW'(WIDTH - 1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ma  <= '0;
      mb  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (accept && start_mul) begin
      ma  <= a;
      mb  <= b;
      acc <= '0;
      cnt <= '0;
    end else if (state == MUL) begin
      acc <= acc_n;
      ma  <= ma << 1;
      mb  <= mb >> 1;
      cnt <= cnt + CW'(1);
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
`ifdef ALU_SEQ_MUL_EN
        if (bus.in_valid_i) state_n = start_mul ? MUL : DONE;
`else
        if (bus.in_valid_i) state_n = DONE;
`endif
      end
`ifdef ALU_SEQ_MUL_EN
      MUL:  if (last) state_n = DONE;
`endif
      DONE: if (bus.out_ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept && !start_mul) begin
      result_q <= res_c;
      zero_q   <= !err_c && (res_c == '0);
      ovf_q    <= ovf_c;
      err_q    <= err_c;
`ifdef ALU_SEQ_MUL_EN
    end else if (state == MUL && last) begin
      result_q <= acc_n;
      zero_q   <= acc_n == '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end
  end

  assign bus.in_ready_o  = state == IDLE;
  assign bus.out_valid_o = state == DONE;
  assign bus.result_o    = result_q;
  assign bus.zero_o      = zero_q;
  assign bus.overflow_o  = ovf_q;
  assign bus.err_o       = err_q;
`ifdef ALU_SEQ_MUL_EN
  assign bus.busy_o      = state == MUL;
`else
  assign bus.busy_o      = 1'b0;
`endif
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed vectors with hand-computed results for alu_seq_exec.
// Builds with or without ALU_SEQ_MUL_EN.
module tb_alu_seq_exec;
  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  alu_seq_exec_if #(.WIDTH(32)) bus ();

  alu_seq_exec #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one request for one edge, then scramble the operand lines
  task automatic issue(input logic [3:0] op,
                       input logic [31:0] x,
                       input logic [31:0] y);
    bus.in_valid_i = 1'b1;
    bus.ALUCtrl_i  = op;
    bus.src1_i     = x;
    bus.src2_i     = y;
    tick();
    bus.in_valid_i = 1'b0;
    bus.ALUCtrl_i  = 4'b0110;
    bus.src1_i     = $urandom;
    bus.src2_i     = $urandom;
  endtask

  task automatic drain();
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    check("drain_ready", 32'(bus.in_ready_o), 32'd1);
    check("drain_valid", 32'(bus.out_valid_o), 32'd0);
  endtask

  initial begin
    int busy_cnt;
    vectors = 0;
    errors  = 0;
    rst             = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.ALUCtrl_i   = 4'b0000;
    bus.src1_i      = '0;
    bus.src2_i      = '0;
    bus.out_ready_i = 1'b0;
    repeat (3) tick();

    check("rst_result", bus.result_o, 32'd0);
    check("rst_zero", 32'(bus.zero_o), 32'd0);
    check("rst_ovf", 32'(bus.overflow_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    check("rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_ready", 32'(bus.in_ready_o), 32'd1);
    rst = 1'b1;
    tick();

    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add_valid", 32'(bus.out_valid_o), 32'd1);
    check("add_result", bus.result_o, 32'h8000_0000);
    check("add_ovf", 32'(bus.overflow_o), 32'd1);
    check("add_zero", 32'(bus.zero_o), 32'd0);
    check("add_err", 32'(bus.err_o), 32'd0);
    check("add_ready", 32'(bus.in_ready_o), 32'd0);
    drain();

    issue(4'b0110, 32'd5, 32'd5);
    bus.in_valid_i = 1'b1;
    bus.ALUCtrl_i  = 4'b0010;
    bus.src1_i     = 32'd1;
    bus.src2_i     = 32'd1;
    for (int i = 0; i < 4; i++) begin
      check("sub_result", bus.result_o, 32'd0);
      check("sub_zero", 32'(bus.zero_o), 32'd1);
      check("sub_ready", 32'(bus.in_ready_o), 32'd0);
      check("sub_valid", 32'(bus.out_valid_o), 32'd1);
      tick();
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    check("sub_idle", 32'(bus.in_ready_o), 32'd1);
    check("sub_novalid", 32'(bus.out_valid_o), 32'd0);
    check("sub_hold", bus.result_o, 32'd0);

    issue(4'b0110, 32'h8000_0000, 32'h0000_0001);
    check("subov_result", bus.result_o, 32'h7FFF_FFFF);
    check("subov_ovf", 32'(bus.overflow_o), 32'd1);
    drain();

    issue(4'b0111, 32'h8000_0000, 32'h0000_0001);
    check("slt1_result", bus.result_o, 32'd1);
    check("slt1_ovf", 32'(bus.overflow_o), 32'd0);
    drain();
    issue(4'b0111, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    check("slt2_result", bus.result_o, 32'd0);
    check("slt2_ovf", 32'(bus.overflow_o), 32'd0);
    check("slt2_zero", 32'(bus.zero_o), 32'd1);
    drain();

    issue(4'b1111, 32'd3, 32'd4);
    check("ill_err", 32'(bus.err_o), 32'd1);
    check("ill_result", bus.result_o, 32'd0);
    check("ill_zero", 32'(bus.zero_o), 32'd0);
    check("ill_valid", 32'(bus.out_valid_o), 32'd1);
    drain();
    issue(4'b0000, 32'h0000_00F0, 32'h0000_003C);
    check("and_result", bus.result_o, 32'h0000_0030);
    check("and_err", 32'(bus.err_o), 32'd0);
    drain();
    issue(4'b0001, 32'h0000_00F0, 32'h0000_000F);
    check("or_result", bus.result_o, 32'h0000_00FF);
    drain();

`ifdef ALU_SEQ_MUL_EN
    issue(4'b0011, 32'hFFFF_FFFF, 32'd3);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy_o !== 1'b1) break;
      if (bus.out_valid_o !== 1'b0) break;
      busy_cnt++;
      tick();
    end
    check("mul_busy_cycles", 32'(busy_cnt), 32'd32);
    check("mul_valid", 32'(bus.out_valid_o), 32'd1);
    check("mul_result", bus.result_o, 32'hFFFF_FFFD);
    check("mul_err", 32'(bus.err_o), 32'd0);
    check("mul_ovf", 32'(bus.overflow_o), 32'd0);
    drain();

    issue(4'b0011, 32'd7, 32'd9);
    for (int i = 0; i < 9; i++) begin
      check("mulrst_novalid", 32'(bus.out_valid_o), 32'd0);
      tick();
    end
`else
    busy_cnt = 0;
    issue(4'b0011, 32'hFFFF_FFFF, 32'd3);
    check("mul_err", 32'(bus.err_o), 32'd1);
    check("mul_valid", 32'(bus.out_valid_o), 32'd1);
    check("mul_result", bus.result_o, 32'd0);
    check("mul_busy", 32'(bus.busy_o), 32'(busy_cnt));
    drain();

    issue(4'b0011, 32'd7, 32'd9);
`endif
    rst = 1'b0;
    #1;
    check("mrst_ready", 32'(bus.in_ready_o), 32'd1);
    check("mrst_valid", 32'(bus.out_valid_o), 32'd0);
    check("mrst_busy", 32'(bus.busy_o), 32'd0);
    check("mrst_result", bus.result_o, 32'd0);
    check("mrst_err", 32'(bus.err_o), 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_quiet", 32'(bus.out_valid_o), 32'd0);
    end

    issue(4'b0010, 32'd2, 32'd2);
    check("post_add", bus.result_o, 32'd4);
    check("post_valid", 32'(bus.out_valid_o), 32'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end
endmodule
